// File: rtl/regbnk_ctrl_if.sv
// Command/response bundle between the datapath decoder and regbnk_ctrl.
// The decoder (master) issues one command at a time over a valid/ready
// handshake. The controller (slave) returns one response per command over
// a second valid/ready handshake.
interface regbnk_ctrl_if #(
  parameter int DW = 16,
  parameter int AW = 4
) ();

  // Command channel
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_addr2;
  logic [DW-1:0] cmd_wdata;

  // Response channel
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          resp_ovf;
  logic          resp_err;

  // Requester side: drives commands and consumes responses.
  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_addr2, cmd_wdata, resp_ready,
    input  cmd_ready, resp_valid, resp_data, resp_ovf, resp_err
  );

  // Controller side: accepts commands and produces responses.
  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_addr2, cmd_wdata, resp_ready,
    output cmd_ready, resp_valid, resp_data, resp_ovf, resp_err
  );

endinterface

// File: rtl/regbnk_ctrl.sv
// regbnk_ctrl: command-driven initiator for a 16 x 16-bit single-port
// register bank. Only one command is in flight at a time. Every output is
// driven straight from a flop. Each flop is loaded on the edge that enters
// a state, so a state's pin values are already present during the whole of
// that state's cycle.
//
// Operations:
//   READ   - read one register
//   WRITE  - write one register
//   ADD    - read-modify-write add, with carry-out reported in resp_ovf
//   COPY   - copy one register to another
//   CLEAR  - one-cycle synchronous clear pulse to the whole bank
//
// Any other opcode is answered at once with resp_err set. The bank port is
// never touched for an illegal opcode.
module regbnk_ctrl #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  regbnk_ctrl_if.slave  bus,
  output logic          bank_cs,
  output logic          bank_rw,
  output logic [AW-1:0] bank_addr,
  output logic [DW-1:0] bank_datin,
  input  logic [DW-1:0] bank_datout,
  output logic          bank_rst
);

  // Opcodes
  localparam logic [2:0] OP_READ  = 3'b000;
  localparam logic [2:0] OP_WRITE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_COPY  = 3'b011;
  localparam logic [2:0] OP_CLEAR = 3'b100;

  // FSM states
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD_ISSUE = 3'd1;
  localparam logic [2:0] ST_RD_WAIT  = 3'd2;
  localparam logic [2:0] ST_WR_ISSUE = 3'd3;
  localparam logic [2:0] ST_CLR      = 3'd4;
  localparam logic [2:0] ST_RESP     = 3'd5;

  // Sum and carry-out for ADD. The result is one bit wider than the data,
  // so the top bit is the carry and the low DW bits wrap modulo 2^DW.
  function automatic logic [DW:0] add_carry(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    add_carry = {1'b0, a} + {1'b0, b};
  endfunction

  // FSM state
  logic [2:0]    state_q, state_d;

  // Command fields latched on accept
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] addr2_q, addr2_d;
  logic [DW-1:0] wdata_q, wdata_d;

  // Command and response channel outputs
  logic          cmd_ready_q, cmd_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [DW-1:0] resp_data_q, resp_data_d;
  logic          resp_ovf_q, resp_ovf_d;
  logic          resp_err_q, resp_err_d;

  // Bank port outputs
  logic          bank_cs_q, bank_cs_d;
  logic          bank_rw_q, bank_rw_d;
  logic [AW-1:0] bank_addr_q, bank_addr_d;
  logic [DW-1:0] bank_datin_q, bank_datin_d;
  logic          bank_rst_q, bank_rst_d;

  // Read data plus the addend, valid while in RD_WAIT
  logic [DW:0]   sum_s;

  // Next-state and next-output logic. Every register holds its value unless
  // a transition below changes it.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    addr2_d      = addr2_q;
    wdata_d      = wdata_q;
    cmd_ready_d  = cmd_ready_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_ovf_d   = resp_ovf_q;
    resp_err_d   = resp_err_q;
    bank_cs_d    = bank_cs_q;
    bank_rw_d    = bank_rw_q;
    bank_addr_d  = bank_addr_q;
    bank_datin_d = bank_datin_q;
    bank_rst_d   = bank_rst_q;
    sum_s        = add_carry(bank_datout, wdata_q);

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          op_d        = bus.cmd_op;
          addr_d      = bus.cmd_addr;
          addr2_d     = bus.cmd_addr2;
          wdata_d     = bus.cmd_wdata;
          resp_ovf_d  = 1'b0;
          resp_err_d  = 1'b0;
          cmd_ready_d = 1'b0;
          case (bus.cmd_op)
            OP_READ, OP_ADD, OP_COPY: begin
              // Every read-based command starts with a read of the source register.
              state_d     = ST_RD_ISSUE;
              bank_cs_d   = 1'b1;
              bank_rw_d   = 1'b1;
              bank_addr_d = bus.cmd_addr;
            end
            OP_WRITE: begin
              // The write data is known now, so the response value is set here too.
              state_d      = ST_WR_ISSUE;
              bank_cs_d    = 1'b1;
              bank_rw_d    = 1'b0;
              bank_addr_d  = bus.cmd_addr;
              bank_datin_d = bus.cmd_wdata;
              resp_data_d  = bus.cmd_wdata;
            end
            OP_CLEAR: begin
              state_d     = ST_CLR;
              bank_rst_d  = 1'b1;
              resp_data_d = {DW{1'b0}};
            end
            default: begin
              // Illegal opcode: respond straight away and leave the bank alone.
              state_d      = ST_RESP;
              resp_err_d   = 1'b1;
              resp_data_d  = {DW{1'b0}};
              resp_valid_d = 1'b1;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RD_ISSUE: begin
        // The bank captures the read on this edge. Its data is valid next cycle.
        state_d   = ST_RD_WAIT;
        bank_cs_d = 1'b0;
        bank_rw_d = 1'b1;
      end

      ST_RD_WAIT: begin
        case (op_q)
          OP_ADD: begin
            state_d      = ST_WR_ISSUE;
            resp_ovf_d   = sum_s[DW];
            resp_data_d  = sum_s[DW-1:0];
            bank_datin_d = sum_s[DW-1:0];
            bank_addr_d  = addr_q;
            bank_cs_d    = 1'b1;
            bank_rw_d    = 1'b0;
          end
          OP_COPY: begin
            // The destination may equal the source. That register then rewrites its own value.
            state_d      = ST_WR_ISSUE;
            resp_data_d  = bank_datout;
            bank_datin_d = bank_datout;
            bank_addr_d  = addr2_q;
            bank_cs_d    = 1'b1;
            bank_rw_d    = 1'b0;
          end
          default: begin
            state_d      = ST_RESP;
            resp_data_d  = bank_datout;
            resp_valid_d = 1'b1;
          end
        endcase
      end

      ST_WR_ISSUE: begin
        // The bank commits the write on this edge. The response is offered from here on.
        state_d      = ST_RESP;
        bank_cs_d    = 1'b0;
        bank_rw_d    = 1'b1;
        resp_valid_d = 1'b1;
      end

      ST_CLR: begin
        state_d      = ST_RESP;
        bank_rst_d   = 1'b0;
        resp_valid_d = 1'b1;
      end

      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          cmd_ready_d  = 1'b1;
        end else begin
          resp_valid_d = 1'b1;
        end
      end

      default: begin
        // Unreachable encoding: go back to a safe idle state with the bank released.
        state_d      = ST_IDLE;
        cmd_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        bank_cs_d    = 1'b0;
        bank_rw_d    = 1'b1;
        bank_rst_d   = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset clears bank_cs at once, so a write already in progress is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= 3'b000;
      addr_q       <= {AW{1'b0}};
      addr2_q      <= {AW{1'b0}};
      wdata_q      <= {DW{1'b0}};
      cmd_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= {DW{1'b0}};
      resp_ovf_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      bank_cs_q    <= 1'b0;
      bank_rw_q    <= 1'b1;
      bank_addr_q  <= {AW{1'b0}};
      bank_datin_q <= {DW{1'b0}};
      bank_rst_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      addr2_q      <= addr2_d;
      wdata_q      <= wdata_d;
      cmd_ready_q  <= cmd_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_ovf_q   <= resp_ovf_d;
      resp_err_q   <= resp_err_d;
      bank_cs_q    <= bank_cs_d;
      bank_rw_q    <= bank_rw_d;
      bank_addr_q  <= bank_addr_d;
      bank_datin_q <= bank_datin_d;
      bank_rst_q   <= bank_rst_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_ovf   = resp_ovf_q;
  assign bus.resp_err   = resp_err_q;
  assign bank_cs        = bank_cs_q;
  assign bank_rw        = bank_rw_q;
  assign bank_addr      = bank_addr_q;
  assign bank_datin     = bank_datin_q;
  assign bank_rst       = bank_rst_q;

endmodule

// File: tb/tb_regbnk_ctrl.sv
// Self-checking bench for regbnk_ctrl.
// It contains a behavioural model of the 16 x 16 register bank. Each
// command pushes its expected response onto a scoreboard queue, using a
// reference copy of the register contents. The expected entry is popped
// and compared when the controller presents the response.
//
// Latency is counted in clock edges, with the accept edge counted as
// edge 1.
module tb_regbnk_ctrl;

  localparam int DW = 16;
  localparam int AW = 4;

  localparam logic [2:0] OP_READ  = 3'b000;
  localparam logic [2:0] OP_WRITE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_COPY  = 3'b011;
  localparam logic [2:0] OP_CLEAR = 3'b100;
  localparam logic [2:0] OP_BAD   = 3'b111;

  typedef struct {
    logic [DW-1:0] data;
    logic          ovf;
    logic          err;
    int            lat;
  } exp_t;

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] a;
    logic [AW-1:0] a2;
    logic [DW-1:0] wd;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bank_cs;
  logic          bank_rw;
  logic          bank_rst;
  logic [AW-1:0] bank_addr;
  logic [DW-1:0] bank_datin;
  logic [DW-1:0] bank_datout;

  int            checks = 0;
  int            errors = 0;
  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [16];

  // Results captured by the most recent call to do_cmd
  logic [DW-1:0] r_data;
  logic          r_ovf;
  logic          r_err;
  int            r_lat;
  int            r_acc;

  // Free-running counters, sampled by the test tasks
  int            cyc = 0;
  int            cs_count = 0;
  int            rst_pulses = 0;

  regbnk_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  regbnk_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .bank_cs    (bank_cs),
    .bank_rw    (bank_rw),
    .bank_addr  (bank_addr),
    .bank_datin (bank_datin),
    .bank_datout(bank_datout),
    .bank_rst   (bank_rst)
  );

  always #5 clk = ~clk;

  // Register bank model. Data from a read is registered, so it is valid in
  // the cycle after the read edge.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (bank_rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (bank_cs && !bank_rw) begin
      mem[bank_addr] <= bank_datin;
    end else if (bank_cs && bank_rw) begin
      bank_datout <= mem[bank_addr];
    end
  end

  // Cycle, chip-select and clear-pulse counters
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bank_cs)  cs_count   <= cs_count + 1;
    if (bank_rst) rst_pulses <= rst_pulses + 1;
  end

  // Reference model: compute the expected response and update the reference register contents.
  task automatic push_exp(input cmd_t c);
    exp_t e;
    logic [DW:0] s;
    e.data = '0; e.ovf = 1'b0; e.err = 1'b0; e.lat = 0;
    case (c.op)
      OP_READ:  begin e.data = ref_mem[c.a]; e.lat = 3; end
      OP_WRITE: begin ref_mem[c.a] = c.wd; e.data = c.wd; e.lat = 2; end
      OP_ADD: begin
        s = {1'b0, ref_mem[c.a]} + {1'b0, c.wd};
        ref_mem[c.a] = s[DW-1:0];
        e.data = s[DW-1:0]; e.ovf = s[DW]; e.lat = 4;
      end
      OP_COPY:  begin e.data = ref_mem[c.a]; ref_mem[c.a2] = ref_mem[c.a]; e.lat = 4; end
      OP_CLEAR: begin for (int i = 0; i < 16; i++) ref_mem[i] = '0; e.lat = 2; end
      default:  begin e.err = 1'b1; e.lat = 1; end
    endcase
    exp_q.push_back(e);
  endtask

  // Drive one command, wait for its response and accept it. A bounded wait that runs out is counted as a failure.
  task automatic do_cmd(input cmd_t c);
    int guard;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = c.op;
    bus.cmd_addr  = c.a;
    bus.cmd_addr2 = c.a2;
    bus.cmd_wdata = c.wd;
    guard = 0;
    while (!bus.cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout: cmd_ready=%b, required 1", bus.cmd_ready);
    end
    @(posedge clk); #1;
    r_acc = cyc;
    bus.cmd_valid = 1'b0;
    r_lat = 1;
    while (!bus.resp_valid && r_lat < 50) begin
      @(posedge clk); #1;
      r_lat++;
    end
    if (!bus.resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout: resp_valid=%b, required 1", bus.resp_valid);
    end
    r_data = bus.resp_data;
    r_ovf  = bus.resp_ovf;
    r_err  = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  // Queue the expected response for a command, then run the command.
  task automatic run(input cmd_t c);
    push_exp(c);
    do_cmd(c);
  endtask

  // Check every output while reset is held.
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.cmd_ready, bus.resp_valid, bus.resp_ovf, bus.resp_err, bank_cs, bank_rw, bank_rst} !== 7'b1000010) begin
      errors++;
      $display("FAIL reset_ctrl: got {rdy,rv,ovf,err,cs,rw,rst}=%b, required 1000010",
               {bus.cmd_ready, bus.resp_valid, bus.resp_ovf, bus.resp_err, bank_cs, bank_rw, bank_rst});
    end
    checks++;
    if ({bus.resp_data, bank_addr, bank_datin} !== '0) begin
      errors++;
      $display("FAIL reset_data: got resp_data=%h addr=%h datin=%h, required all 0", bus.resp_data, bank_addr, bank_datin);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // WRITE 0xBEEF to register 5, then read it back.
  task automatic test_write_read();
    cmd_t tbl[$];
    exp_t e;
    tbl.push_back('{OP_WRITE, 4'd5, 4'd0, 16'hBEEF});
    tbl.push_back('{OP_READ,  4'd5, 4'd0, 16'h0000});
    tbl.push_back('{OP_WRITE, 4'd0, 4'd0, 16'h0001});
    tbl.push_back('{OP_READ,  4'd0, 4'd0, 16'h0000});
    foreach (tbl[i]) begin
      run(tbl[i]);
      e = exp_q.pop_front();
      checks++;
      if (r_data !== e.data || r_ovf !== e.ovf || r_err !== e.err || r_lat != e.lat) begin
        errors++;
        $display("FAIL write_read[%0d]: got data=%h ovf=%b err=%b lat=%0d, required data=%h ovf=%b err=%b lat=%0d",
                 i, r_data, r_ovf, r_err, r_lat, e.data, e.ovf, e.err, e.lat);
      end
    end
  endtask

  // ADD with carry-out, ADD without carry, then read back the result.
  task automatic test_add();
    cmd_t tbl[$];
    exp_t e;
    tbl.push_back('{OP_WRITE, 4'd3, 4'd0, 16'hFFF0});
    tbl.push_back('{OP_ADD,   4'd3, 4'd0, 16'h0020});
    tbl.push_back('{OP_READ,  4'd3, 4'd0, 16'h0000});
    tbl.push_back('{OP_ADD,   4'd3, 4'd0, 16'h0005});
    tbl.push_back('{OP_READ,  4'd3, 4'd0, 16'h0000});
    foreach (tbl[i]) begin
      run(tbl[i]);
      e = exp_q.pop_front();
      checks++;
      if (r_data !== e.data || r_ovf !== e.ovf || r_err !== e.err || r_lat != e.lat) begin
        errors++;
        $display("FAIL add[%0d]: got data=%h ovf=%b err=%b lat=%0d, required data=%h ovf=%b err=%b lat=%0d",
                 i, r_data, r_ovf, r_err, r_lat, e.data, e.ovf, e.err, e.lat);
      end
    end
  endtask

  // COPY to a different register and to the same register. The source must be left unchanged.
  task automatic test_copy();
    cmd_t tbl[$];
    exp_t e;
    tbl.push_back('{OP_WRITE, 4'd1,  4'd0,  16'h1234});
    tbl.push_back('{OP_COPY,  4'd1,  4'd15, 16'h0000});
    tbl.push_back('{OP_READ,  4'd15, 4'd0,  16'h0000});
    tbl.push_back('{OP_READ,  4'd1,  4'd0,  16'h0000});
    tbl.push_back('{OP_WRITE, 4'd2,  4'd0,  16'h5A5A});
    tbl.push_back('{OP_COPY,  4'd2,  4'd2,  16'h0000});
    tbl.push_back('{OP_READ,  4'd2,  4'd0,  16'h0000});
    foreach (tbl[i]) begin
      run(tbl[i]);
      e = exp_q.pop_front();
      checks++;
      if (r_data !== e.data || r_ovf !== e.ovf || r_err !== e.err || r_lat != e.lat) begin
        errors++;
        $display("FAIL copy[%0d]: got data=%h ovf=%b err=%b lat=%0d, required data=%h ovf=%b err=%b lat=%0d",
                 i, r_data, r_ovf, r_err, r_lat, e.data, e.ovf, e.err, e.lat);
      end
    end
  endtask

  // Fill every register, CLEAR the bank, then read every register back.
  task automatic test_clear();
    cmd_t c;
    exp_t e;
    int   p0;
    int   c0;
    for (int i = 0; i < 16; i++) begin
      c = '{OP_WRITE, i[AW-1:0], 4'd0, 16'(i + 1)};
      run(c);
      e = exp_q.pop_front();
      checks++;
      if (r_data !== e.data || r_lat != e.lat) begin
        errors++;
        $display("FAIL fill[%0d]: got data=%h lat=%0d, required data=%h lat=%0d", i, r_data, r_lat, e.data, e.lat);
      end
    end
    p0 = rst_pulses;
    c0 = cs_count;
    c  = '{OP_CLEAR, 4'd0, 4'd0, 16'h0000};
    run(c);
    e = exp_q.pop_front();
    checks++;
    if (r_data !== e.data || r_ovf !== e.ovf || r_err !== e.err || r_lat != e.lat) begin
      errors++;
      $display("FAIL clear_resp: got data=%h ovf=%b err=%b lat=%0d, required data=%h ovf=%b err=%b lat=%0d",
               r_data, r_ovf, r_err, r_lat, e.data, e.ovf, e.err, e.lat);
    end
    checks++;
    if (rst_pulses - p0 != 1 || cs_count != c0) begin
      errors++;
      $display("FAIL clear_pulse: got bank_rst cycles=%0d cs cycles=%0d, required 1 and 0", rst_pulses - p0, cs_count - c0);
    end
    for (int i = 0; i < 16; i++) begin
      c = '{OP_READ, i[AW-1:0], 4'd0, 16'h0000};
      run(c);
      e = exp_q.pop_front();
      checks++;
      if (r_data !== e.data || r_lat != e.lat) begin
        errors++;
        $display("FAIL clear_read[%0d]: got data=%h lat=%0d, required data=%h lat=%0d", i, r_data, r_lat, e.data, e.lat);
      end
    end
  endtask

  // Illegal opcode: immediate error response, no bank access, response held stable while resp_ready stays low.
  task automatic test_illegal();
    cmd_t c;
    exp_t e;
    int   c0;
    c  = '{OP_BAD, 4'd9, 4'd3, 16'h1234};
    push_exp(c);
    e  = exp_q.pop_front();
    c0 = cs_count;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_ready: cmd_ready=%b, required 1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = c.op;
    bus.cmd_addr  = c.a;
    bus.cmd_addr2 = c.a2;
    bus.cmd_wdata = c.wd;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_err !== e.err || bus.resp_data !== e.data || bus.resp_ovf !== e.ovf) begin
      errors++;
      $display("FAIL illegal_resp: got rv=%b err=%b data=%h ovf=%b after 1 edge, required rv=1 err=%b data=%h ovf=%b",
               bus.resp_valid, bus.resp_err, bus.resp_data, bus.resp_ovf, e.err, e.data, e.ovf);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_data !== e.data || bus.cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL illegal_hold[%0d]: got rv=%b err=%b data=%h rdy=%b, required rv=1 err=1 data=%h rdy=0",
                 k, bus.resp_valid, bus.resp_err, bus.resp_data, bus.cmd_ready, e.data);
      end
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || cs_count != c0) begin
      errors++;
      $display("FAIL illegal_done: got rv=%b rdy=%b cs cycles=%0d, required rv=0 rdy=1 cs cycles=0",
               bus.resp_valid, bus.cmd_ready, cs_count - c0);
    end
  endtask

  // With the response taken at once, the command period must be latency + 1.
  task automatic test_back_to_back();
    cmd_t tbl[$];
    exp_t e;
    int   prev;
    int   per [4];
    tbl.push_back('{OP_READ,  4'd5, 4'd0, 16'h0000});
    tbl.push_back('{OP_READ,  4'd5, 4'd0, 16'h0000});
    tbl.push_back('{OP_WRITE, 4'd6, 4'd0, 16'h00AA});
    tbl.push_back('{OP_WRITE, 4'd6, 4'd0, 16'h0055});
    per = '{0, 4, 0, 3};
    prev = 0;
    foreach (tbl[i]) begin
      run(tbl[i]);
      e = exp_q.pop_front();
      checks++;
      if (r_data !== e.data || r_lat != e.lat || (per[i] != 0 && r_acc - prev != per[i])) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got data=%h lat=%0d period=%0d, required data=%h lat=%0d period=%0d",
                 i, r_data, r_lat, r_acc - prev, e.data, e.lat, per[i]);
      end
      prev = r_acc;
    end
  endtask

  // Assert reset during the write cycle of an ADD. The write must be abandoned with no bank_rst pulse.
  task automatic test_reset_mid_add();
    cmd_t c;
    exp_t e;
    int   p0;
    c = '{OP_WRITE, 4'd7, 4'd0, 16'h1111};
    run(c);
    e = exp_q.pop_front();
    checks++;
    if (r_data !== e.data) begin
      errors++;
      $display("FAIL rst_add_setup: got data=%h, required %h", r_data, e.data);
    end
    p0 = rst_pulses;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_addr  = 4'd7;
    bus.cmd_addr2 = 4'd0;
    bus.cmd_wdata = 16'h0001;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bank_cs !== 1'b1 || bank_rw !== 1'b0) begin
      errors++;
      $display("FAIL rst_add_wr_issue: got cs=%b rw=%b, required cs=1 rw=0", bank_cs, bank_rw);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.cmd_ready, bus.resp_valid, bus.resp_ovf, bus.resp_err, bank_cs, bank_rw, bank_rst} !== 7'b1000010 ||
        {bus.resp_data, bank_addr, bank_datin} !== '0) begin
      errors++;
      $display("FAIL rst_async: got {rdy,rv,ovf,err,cs,rw,rst}=%b data=%h addr=%h datin=%h, required 1000010 and zeros",
               {bus.cmd_ready, bus.resp_valid, bus.resp_ovf, bus.resp_err, bank_cs, bank_rw, bank_rst},
               bus.resp_data, bank_addr, bank_datin);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (mem[7] !== ref_mem[7] || bus.cmd_ready !== 1'b1 || rst_pulses != p0) begin
      errors++;
      $display("FAIL rst_add_after: got r7=%h rdy=%b bank_rst cycles=%0d, required r7=%h rdy=1 bank_rst cycles=0",
               mem[7], bus.cmd_ready, rst_pulses - p0, ref_mem[7]);
    end
    c = '{OP_READ, 4'd7, 4'd0, 16'h0000};
    run(c);
    e = exp_q.pop_front();
    checks++;
    if (r_data !== e.data || r_lat != e.lat) begin
      errors++;
      $display("FAIL rst_add_readback: got data=%h lat=%0d, required data=%h lat=%0d", r_data, r_lat, e.data, e.lat);
    end
  endtask

  // Test sequence
  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 3'b000;
    bus.cmd_addr   = '0;
    bus.cmd_addr2  = '0;
    bus.cmd_wdata  = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    test_reset();
    test_write_read();
    test_add();
    test_copy();
    test_clear();
    test_illegal();
    test_back_to_back();
    test_reset_mid_add();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
